// File: rtl/ext_trig_mon.sv
// Per-channel outstanding-trigger counter: +1 on trigger rise, -1 on frame rise, with sticky flags and watermark.
// Latency: input edge -> count 3 clk edges, flags 4, overflow_any 5. No backpressure; rises while disabled are dropped.
module ext_trig_mon #(
  parameter int N_CH       = 4,
  parameter int CNT_W      = 8,
  parameter int OVF_THRESH = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_CH-1:0]         en_cnt,
  input  logic [N_CH-1:0]         ext_trig,
  input  logic [N_CH-1:0]         frame_start,
  input  logic                    clr,
  output logic [N_CH*CNT_W-1:0]   cnt_out,
  output logic [N_CH*CNT_W-1:0]   wmark_out,
  output logic [N_CH-1:0]         ext_trig_overflow,
  output logic [N_CH-1:0]         frame_underflow,
  output logic                    overflow_any
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] THRESH  = CNT_W'(OVF_THRESH);

  logic [N_CH-1:0] trig_s1_q, trig_s2_q, trig_s3_q;
  logic [N_CH-1:0] frm_s1_q, frm_s2_q, frm_s3_q;
  logic [N_CH-1:0] en_s1_q, en_q;
  logic [N_CH-1:0] trig_rise, frm_rise;

  logic [N_CH-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [N_CH-1:0][CNT_W-1:0] wmark_q, wmark_d;
  logic [N_CH-1:0]            ovf_q, ovf_d;
  logic [N_CH-1:0]            uf_q, uf_d;
  logic [N_CH-1:0]            uf_evt_q, uf_evt_d;
  logic                       ovf_any_q, ovf_any_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trig_s1_q <= '0;
      trig_s2_q <= '0;
      trig_s3_q <= '0;
      frm_s1_q  <= '0;
      frm_s2_q  <= '0;
      frm_s3_q  <= '0;
      en_s1_q   <= '0;
      en_q      <= '0;
    end else begin
      trig_s1_q <= ext_trig;
      trig_s2_q <= trig_s1_q;
      trig_s3_q <= trig_s2_q;
      frm_s1_q  <= frame_start;
      frm_s2_q  <= frm_s1_q;
      frm_s3_q  <= frm_s2_q;
      en_s1_q   <= en_cnt;
      en_q      <= en_s1_q;
    end
  end

  assign trig_rise = trig_s2_q & ~trig_s3_q;
  assign frm_rise  = frm_s2_q & ~frm_s3_q;

  always_comb begin
    cnt_d     = cnt_q;
    wmark_d   = wmark_q;
    ovf_d     = ovf_q;
    uf_d      = uf_q;
    uf_evt_d  = '0;
    ovf_any_d = |ovf_q;
    if (clr) begin
      cnt_d     = '0;
      wmark_d   = '0;
      ovf_d     = '0;
      uf_d      = '0;
      ovf_any_d = 1'b0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (en_q[i]) begin
          if (trig_rise[i] && !frm_rise[i]) begin
            if (cnt_q[i] != CNT_MAX) cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end else if (frm_rise[i] && !trig_rise[i]) begin
            if (cnt_q[i] != '0) cnt_d[i] = cnt_q[i] - CNT_W'(1);
            else                uf_evt_d[i] = 1'b1;
          end
        end
        if (cnt_q[i] > wmark_q[i]) wmark_d[i] = cnt_q[i];
        // Flags follow the registered count/event, so they land one edge after the count.
        if (cnt_q[i] > THRESH) ovf_d[i] = 1'b1;
        if (uf_evt_q[i])       uf_d[i]  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      wmark_q   <= '0;
      ovf_q     <= '0;
      uf_q      <= '0;
      uf_evt_q  <= '0;
      ovf_any_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      wmark_q   <= wmark_d;
      ovf_q     <= ovf_d;
      uf_q      <= uf_d;
      uf_evt_q  <= uf_evt_d;
      ovf_any_q <= ovf_any_d;
    end
  end

  assign cnt_out           = cnt_q;
  assign wmark_out         = wmark_q;
  assign ext_trig_overflow = ovf_q;
  assign frame_underflow   = uf_q;
  assign overflow_any      = ovf_any_q;

endmodule
